trace_line_parser: RTL and testbench

Parses the ASCII byte stream produced by the SD-card file reader (one byte per `in_valid` strobe, no back-pressure possible) into fixed-width memory-access records for the LRU cache model. Each text line holds one access: an optional op character, whitespace, and a hex address with an optional `0x` prefix. Completed records are buffered in an internal FIFO and drained through a valid/ready interface. Address width, FIFO depth and counter width are parametrised; malformed lines and overflow drops are counted.

---
 rtl/trace_pkg.sv | 51 +++++
 rtl/trace_fifo.sv | 56 +++++
 rtl/trace_line_parser.sv | 164 ++++++++++++++++
 tb/tb_trace_line_parser.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_pkg: byte classes, parser states and helpers for trace parsing |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package trace_pkg;

  localparam logic [7:0] c_LF  = 8'h0A;
  localparam logic [7:0] c_CR  = 8'h0D;
  localparam logic [7:0] c_SP  = 8'h20;
  localparam logic [7:0] c_TAB = 8'h09;

  localparam logic [2:0] S_START = 3'd0;
  localparam logic [2:0] S_OP    = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_TAIL  = 3'd3;
  localparam logic [2:0] S_SKIP  = 3'd4;

  typedef enum logic [2:0] {
    BC_LF  = 3'd0,
    BC_CR  = 3'd1,
    BC_SEP = 3'd2,
    BC_OP  = 3'd3,
    BC_HEX = 3'd4,
    BC_X   = 3'd5,
    BC_BAD = 3'd6
  } byte_class_e;

  function automatic byte_class_e classify(input logic [7:0] b);
    byte_class_e r;
    r = BC_BAD;
    if (b == c_LF)                            r = BC_LF;
    else if (b == c_CR)                       r = BC_CR;
    else if (b == c_SP || b == c_TAB)         r = BC_SEP;
    else if (b == "R" || b == "r" || b == "W" || b == "w") r = BC_OP;
    else if (b == "x" || b == "X")            r = BC_X;
    else if ((b >= "0" && b <= "9") || (b >= "a" && b <= "f") ||
             (b >= "A" && b <= "F"))          r = BC_HEX;
    return r;
  endfunction

  // Letters a-f/A-F share low nibbles 1..6, so +9 maps them to 10..15.
  function automatic logic [3:0] hex_val(input logic [7:0] b);
    logic [3:0] r;
    if (b <= "9") r = b[3:0];
    else          r = b[3:0] + 4'd9;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_fifo: synchronous first-word-fall-through FIFO with occupancy  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module trace_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_rd;
  logic [c_AW-1:0]  r_wr;
  logic [c_AW:0]    r_level;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == (c_AW+1)'(DEPTH));
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd];
  assign w_pop   = i_pop && !o_empty;
  // When full, the slot being written is the head being popped this cycle.
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_level <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + c_AW'(1);
      end
      if (w_pop) r_rd <= r_rd + c_AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + (c_AW+1)'(1);
      else if (!w_push && w_pop) r_level <= r_level - (c_AW+1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/trace_line_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_line_parser: ASCII trace lines to {write, addr} access records |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module trace_line_parser
  import trace_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [7:0]                    in_byte,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_write,
  output logic [ADDR_W-1:0]             out_addr,
  output logic [CNT_W-1:0]              lines_ok,
  output logic [CNT_W-1:0]              lines_bad,
  output logic [CNT_W-1:0]              drops,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  logic [2:0]        r_state;
  logic              r_write;
  logic [ADDR_W-1:0] r_acc;
  logic [1:0]        r_ndig;
  logic [CNT_W-1:0]  r_ok;
  logic [CNT_W-1:0]  r_bad;
  logic [CNT_W-1:0]  r_drops;

  byte_class_e       w_cls;
  logic [3:0]        w_nib;
  logic [2:0]        w_state_nxt;
  logic              w_write_nxt;
  logic [ADDR_W-1:0] w_acc_nxt;
  logic [1:0]        w_ndig_nxt;
  logic              w_emit;
  logic              w_bad;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_push_ok;

  assign w_cls = classify(in_byte);
  assign w_nib = hex_val(in_byte);

  always_comb begin
    w_state_nxt = r_state;
    w_write_nxt = r_write;
    w_acc_nxt   = r_acc;
    w_ndig_nxt  = r_ndig;
    w_emit      = 1'b0;
    w_bad       = 1'b0;
    if (in_valid && w_cls != BC_CR) begin
      case (r_state)
        S_START: begin
          if (w_cls == BC_OP) begin
            w_write_nxt = (in_byte == "W" || in_byte == "w");
            w_state_nxt = S_OP;
          end else if (w_cls == BC_HEX) begin
            w_write_nxt = 1'b0;
            w_acc_nxt   = {{(ADDR_W-4){1'b0}}, w_nib};
            w_ndig_nxt  = 2'd1;
            w_state_nxt = S_ADDR;
          end else if (w_cls != BC_SEP && w_cls != BC_LF) begin
            w_state_nxt = S_SKIP;
          end
        end
        S_OP: begin
          if (w_cls == BC_HEX) begin
            w_acc_nxt   = {{(ADDR_W-4){1'b0}}, w_nib};
            w_ndig_nxt  = 2'd1;
            w_state_nxt = S_ADDR;
          end else if (w_cls == BC_LF) begin
            w_bad       = 1'b1;
            w_state_nxt = S_START;
          end else if (w_cls != BC_SEP) begin
            w_state_nxt = S_SKIP;
          end
        end
        S_ADDR: begin
          // r_ndig == 0 only right after an accepted "0x" prefix.
          if (w_cls == BC_HEX) begin
            w_acc_nxt  = {r_acc[ADDR_W-5:0], w_nib};
            w_ndig_nxt = (r_ndig == 2'd2) ? 2'd2 : r_ndig + 2'd1;
          end else if (w_cls == BC_X && r_ndig == 2'd1 && r_acc == '0) begin
            w_ndig_nxt = 2'd0;
          end else if (w_cls == BC_SEP && r_ndig != 2'd0) begin
            w_state_nxt = S_TAIL;
          end else if (w_cls == BC_LF) begin
            w_emit      = (r_ndig != 2'd0);
            w_bad       = (r_ndig == 2'd0);
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_SKIP;
          end
        end
        S_TAIL: begin
          if (w_cls == BC_LF) begin
            w_emit      = 1'b1;
            w_state_nxt = S_START;
          end else if (w_cls != BC_SEP) begin
            w_state_nxt = S_SKIP;
          end
        end
        default: begin
          if (w_cls == BC_LF) begin
            w_bad       = 1'b1;
            w_state_nxt = S_START;
          end
        end
      endcase
    end
  end

  assign w_pop     = out_valid && out_ready;
  assign w_push_ok = !w_full || w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_START;
      r_write <= 1'b0;
      r_acc   <= '0;
      r_ndig  <= 2'd0;
      r_ok    <= '0;
      r_bad   <= '0;
      r_drops <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_write <= w_write_nxt;
      r_acc   <= w_acc_nxt;
      r_ndig  <= w_ndig_nxt;
      if (w_emit && w_push_ok && ~&r_ok)     r_ok    <= r_ok + CNT_W'(1);
      if (w_emit && !w_push_ok && ~&r_drops) r_drops <= r_drops + CNT_W'(1);
      if (w_bad && ~&r_bad)                  r_bad   <= r_bad + CNT_W'(1);
    end
  end

  trace_fifo #(
    .WIDTH (ADDR_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_emit),
    .i_data  ({r_write, r_acc}),
    .i_pop   (w_pop),
    .o_data  ({out_write, out_addr}),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (fifo_level)
  );

  assign out_valid = !w_empty;
  assign lines_ok  = r_ok;
  assign lines_bad = r_bad;
  assign drops     = r_drops;

endmodule
`default_nettype wire

// File: tb/tb_trace_line_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_trace_line_parser: directed-vector bench for trace_line_parser    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_trace_line_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        out_ready0 = 1'b0;
  logic        out_ready1 = 1'b0;

  logic        out_valid0, out_write0;
  logic [31:0] out_addr0;
  logic [15:0] ok0, bad0, drops0;
  logic [4:0]  level0;

  logic        out_valid1, out_write1;
  logic [15:0] out_addr1;
  logic [15:0] ok1, bad1, drops1;
  logic [2:0]  level1;

  int n_vec = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  trace_line_parser dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_write(out_write0),
    .out_addr(out_addr0), .lines_ok(ok0), .lines_bad(bad0), .drops(drops0),
    .fifo_level(level0)
  );

  trace_line_parser #(.ADDR_W(16), .FIFO_DEPTH(4), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_write(out_write1),
    .out_addr(out_addr1), .lines_ok(ok1), .lines_bad(bad1), .drops(drops1),
    .fifo_level(level1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_chk(input int sel, input string tag,
                         input logic exp_w, input logic [31:0] exp_a);
    int n = 0;
    while (!(sel == 0 ? out_valid0 : out_valid1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(sel == 0 ? out_valid0 : out_valid1)) begin
      chk({tag, "_valid"}, 64'd0, 64'd1);
    end else begin
      chk({tag, "_w"}, sel == 0 ? out_write0 : out_write1, exp_w);
      chk({tag, "_a"}, sel == 0 ? out_addr0 : {16'h0, out_addr1}, exp_a);
      if (sel == 0) out_ready0 = 1'b1; else out_ready1 = 1'b1;
      @(negedge clk);
      out_ready0 = 1'b0;
      out_ready1 = 1'b0;
    end
  endtask

  initial begin
    do_reset();
    chk("rst_valid", out_valid0, 0);
    chk("rst_write", out_write0, 0);
    chk("rst_addr",  out_addr0, 0);
    chk("rst_ok",    ok0, 0);
    chk("rst_bad",   bad0, 0);
    chk("rst_drops", drops0, 0);
    chk("rst_level", level0, 0);

    // Well-formed lines, with prefix, lower-case op, and a CR before LF
    send_str("R 0x1A2B\n");
    send_str("w 00ff\n");
    send_str("1234");
    send_byte(8'h0D);
    send_byte(8'h0A);
    idle(2);
    chk("t1_level", level0, 3);
    pop_chk(0, "t1_r0", 1'b0, 32'h1A2B);
    pop_chk(0, "t1_r1", 1'b1, 32'h00FF);
    pop_chk(0, "t1_r2", 1'b0, 32'h1234);
    chk("t1_ok",  ok0, 3);
    chk("t1_bad", bad0, 0);

    // Malformed lines and an uncounted blank line
    send_str("R 0x\n");
    send_str("Q 12\n");
    send_str("R 12 34\n");
    send_str("\n");
    idle(2);
    chk("t2_bad",   bad0, 3);
    chk("t2_ok",    ok0, 3);
    chk("t2_valid", out_valid0, 0);
    chk("t2_level", level0, 0);

    // Truncation to a 16-bit address
    do_reset();
    send_str("123456789\n");
    idle(2);
    pop_chk(1, "t3", 1'b0, 32'h6789);
    chk("t3_ok", ok1, 1);

    // Overflow with consumer stalled
    do_reset();
    send_str("R 11\nW 22\nr 33\nw 44\nR 55\nW 66\n");
    idle(2);
    chk("t4_level", level1, 4);
    chk("t4_drops", drops1, 2);
    chk("t4_ok",    ok1, 4);
    pop_chk(1, "t4_r0", 1'b0, 32'h11);
    pop_chk(1, "t4_r1", 1'b1, 32'h22);
    pop_chk(1, "t4_r2", 1'b0, 32'h33);
    pop_chk(1, "t4_r3", 1'b1, 32'h44);
    idle(1);
    chk("t4_empty", out_valid1, 0);

    // Full FIFO, pop coincides with the push on the LF cycle
    do_reset();
    send_str("R 11\nW 22\nr 33\nw 44\n");
    idle(2);
    chk("t5_full", level1, 4);
    send_str("W 77");
    @(negedge clk);
    in_valid   = 1'b1;
    in_byte    = 8'h0A;
    out_ready1 = 1'b1;
    @(negedge clk);
    in_valid   = 1'b0;
    out_ready1 = 1'b0;
    idle(1);
    chk("t5_drops", drops1, 0);
    chk("t5_level", level1, 4);
    chk("t5_ok",    ok1, 5);
    pop_chk(1, "t5_r0", 1'b1, 32'h22);
    pop_chk(1, "t5_r1", 1'b0, 32'h33);
    pop_chk(1, "t5_r2", 1'b1, 32'h44);
    pop_chk(1, "t5_r3", 1'b1, 32'h77);

    // Reset mid-line with records buffered
    do_reset();
    send_str("R 5\nW 1");
    do_reset();
    send_str("W 10\n");
    idle(2);
    chk("t6_level", level0, 1);
    pop_chk(0, "t6_r0", 1'b1, 32'h10);
    idle(1);
    chk("t6_empty", out_valid0, 0);
    chk("t6_ok",    ok0, 1);
    chk("t6_bad",   bad0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
